// File: rtl/serial_add_pkg.sv
// Shared state encoding for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester and the serial adder controller.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;

  modport master (
    output start, a_in, b_in,
    input  busy, done, sum_out, carry_out
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, sum_out, carry_out
  );
endinterface

// File: rtl/full_add_cell.sv
// Combinational full-adder cell: two half adders plus an OR on the carries.
module full_add_cell (
  output logic s,
  output logic co,
  input  logic x,
  input  logic y,
  input  logic ci
);
  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.s(s0), .c(c0), .x(x),  .y(y));
  half_adder u_ha1 (.s(s),  .c(c1), .x(s0), .y(ci));

  assign co = c0 | c1;
endmodule

// File: rtl/half_adder.sv
// Single-bit half adder.
module half_adder (
  output logic s,
  output logic c,
  input  logic x,
  input  logic y
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: loads two operands, adds LSB-first through one full-adder
// cell and a carry flop, then publishes the registered result with a done pulse.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset_b,
  serial_adder_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             c_q;
  logic [CW-1:0]    count;
  logic             cell_s;
  logic             cell_co;
  logic             last;
  logic             busy;
  logic             done;

  full_add_cell u_cell (
    .s  (cell_s),
    .co (cell_co),
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (c_q)
  );

  assign last = (count == CW'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (!reset_b) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nx = ST_SHIFT;
      ST_SHIFT: if (last)      state_nx = ST_DONE;
      ST_DONE:                 state_nx = ST_IDLE;
      default:                 state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_SHIFT);
    done = (state == ST_DONE);
  end

  // Result registers load only on the last-bit edge, so partial sums never leak out.
  always_ff @(posedge clock) begin
    if (!reset_b) begin
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      c_q     <= 1'b0;
      count   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a_in;
            b_sh  <= bus.b_in;
            s_sh  <= '0;
            c_q   <= 1'b0;
            count <= '0;
          end
        end
        ST_SHIFT: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          s_sh <= {cell_s, s_sh[WIDTH-1:1]};
          c_q  <= cell_co;
          if (last) begin
            sum_q   <= {cell_s, s_sh[WIDTH-1:1]};
            carry_q <= cell_co;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.sum_out   = sum_q;
  assign bus.carry_out = carry_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=4.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic reset_b;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(4)) bus4 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (.clock(clk), .reset_b(reset_b), .bus(bus8.slave));
  serial_adder_ctrl #(.WIDTH(4)) dut4 (.clock(clk), .reset_b(reset_b), .bus(bus4.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle, then wait (bounded) for done at a falling edge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     output int lat, output int bn, output bit stable);
    logic [7:0] held;
    @(negedge clk);
    bus8.a_in = a; bus8.b_in = b; bus8.start = 1'b1;
    held = bus8.sum_out;
    @(negedge clk);
    bus8.start = 1'b0;
    lat = 0; bn = 0; stable = 1'b1;
    while (!bus8.done && lat < 40) begin
      if (bus8.busy) bn++;
      if (bus8.sum_out !== held) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b,
                     output int lat, output bit stable);
    logic [3:0] held;
    @(negedge clk);
    bus4.a_in = a; bus4.b_in = b; bus4.start = 1'b1;
    held = bus4.sum_out;
    @(negedge clk);
    bus4.start = 1'b0;
    lat = 0; stable = 1'b1;
    while (!bus4.done && lat < 20) begin
      if (bus4.sum_out !== held) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bn;
    bit stable;
    int d1;
    int d2;
    int n_done;
    int lat_bad;
    int unstable;
    int bad_out;

    reset_b = 1'b0;
    bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0;
    bus4.start = 1'b0; bus4.a_in = '0; bus4.b_in = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(bus8.busy), 64'd0);
    check("reset done", 64'(bus8.done), 64'd0);
    check("reset sum", 64'(bus8.sum_out), 64'd0);
    check("reset carry", 64'(bus8.carry_out), 64'd0);
    reset_b = 1'b1;

    // 0x5A + 0x3C
    op8(8'h5A, 8'h3C, lat, bn, stable);
    check("5a+3c latency", 64'(lat), 64'd8);
    check("5a+3c busy cycles", 64'(bn), 64'd8);
    check("5a+3c sum", 64'(bus8.sum_out), 64'h96);
    check("5a+3c carry", 64'(bus8.carry_out), 64'd0);
    check("5a+3c busy with done", 64'(bus8.busy), 64'd0);
    check("5a+3c no partial", 64'(stable), 64'd1);
    @(negedge clk);
    check("done one cycle", 64'(bus8.done), 64'd0);

    // 0xFF + 0x01
    op8(8'hFF, 8'h01, lat, bn, stable);
    check("ff+01 latency", 64'(lat), 64'd8);
    check("ff+01 sum", 64'(bus8.sum_out), 64'h00);
    check("ff+01 carry", 64'(bus8.carry_out), 64'd1);

    // 0xFF + 0xFF with start held high: done pulses every WIDTH+2 cycles
    bus8.a_in = 8'hFF; bus8.b_in = 8'hFF; bus8.start = 1'b1;
    d1 = -1; d2 = -1;
    for (int i = 0; i < 40 && d2 < 0; i++) begin
      @(negedge clk);
      if (bus8.done) begin
        if (d1 < 0) begin
          d1 = i;
          check("ff+ff sum", 64'(bus8.sum_out), 64'hFE);
          check("ff+ff carry", 64'(bus8.carry_out), 64'd1);
        end else begin
          d2 = i;
        end
      end
    end
    bus8.start = 1'b0;
    check("b2b found two dones", 64'(d2 >= 0), 64'd1);
    check("b2b spacing", 64'(d2 - d1), 64'd10);
    repeat (2) @(negedge clk);

    // Start re-pulsed during SHIFT with other operands must be ignored
    bus8.a_in = 8'h10; bus8.b_in = 8'h20; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    bus8.a_in = 8'hFF; bus8.b_in = 8'hFF; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    lat = 0;
    while (!bus8.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ignore done seen", 64'(bus8.done), 64'd1);
    check("ignore sum", 64'(bus8.sum_out), 64'h30);
    check("ignore carry", 64'(bus8.carry_out), 64'd0);
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done) n_done++;
    end
    check("ignore extra dones", 64'(n_done), 64'd0);

    // Reset asserted mid-SHIFT aborts without a done pulse
    bus8.a_in = 8'h77; bus8.b_in = 8'h11; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-abort busy", 64'(bus8.busy), 64'd1);
    reset_b = 1'b0;
    @(negedge clk);
    check("abort busy", 64'(bus8.busy), 64'd0);
    check("abort done", 64'(bus8.done), 64'd0);
    check("abort sum", 64'(bus8.sum_out), 64'd0);
    check("abort carry", 64'(bus8.carry_out), 64'd0);
    reset_b = 1'b1;
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done) n_done++;
    end
    check("abort no done", 64'(n_done), 64'd0);
    op8(8'h01, 8'h02, lat, bn, stable);
    check("01+02 latency", 64'(lat), 64'd8);
    check("01+02 sum", 64'(bus8.sum_out), 64'h03);
    check("01+02 carry", 64'(bus8.carry_out), 64'd0);

    // WIDTH=4 exhaustive
    lat_bad = 0;
    unstable = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        op4(4'(a), 4'(b), lat, stable);
        if (lat != 4) lat_bad++;
        if (!stable) unstable++;
        check($sformatf("w4 %0d+%0d", a, b), 64'({bus4.carry_out, bus4.sum_out}), 64'(a + b));
      end
    end
    check("w4 latency errors", 64'(lat_bad), 64'd0);
    check("w4 partial sums", 64'(unstable), 64'd0);

    // Idle after reset: outputs stay zero, no done for 50 cycles
    reset_b = 1'b0;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    n_done = 0;
    bad_out = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus8.done || bus4.done) n_done++;
      if (bus8.busy || bus4.busy || bus8.sum_out != 0 || bus8.carry_out
          || bus4.sum_out != 0 || bus4.carry_out) bad_out++;
    end
    check("idle dones", 64'(n_done), 64'd0);
    check("idle outputs", 64'(bad_out), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
